// File: rtl/wb_dual_master_arbiter.sv
// Two-master Wishbone arbiter: instruction (m0) and data (m1) onto one slave.
// Round-robin or fixed priority, cycle locking, ack watchdog with abort.
module wb_dual_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  output logic [1:0]              grant_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int WW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1,
    ABORT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_last;
  logic [WW-1:0]   r_wdog;

  logic            w_req0;
  logic            w_req1;
  logic            w_act;
  logic            w_cyc;
  logic            w_stb;
  logic            w_stall;
  logic            w_tmo;
  logic            w_pick0;

  assign w_req0 = m0_cyc_i & m0_stb_i;
  assign w_req1 = m1_cyc_i & m1_stb_i;
  assign w_act  = (r_state == GRANT0) | (r_state == GRANT1);

  // r_last doubles as the current owner once a grant is taken
  assign w_cyc  = r_last ? m1_cyc_i : m0_cyc_i;
  assign w_stb  = r_last ? m1_stb_i : m0_stb_i;

  assign w_stall = w_act & w_cyc & w_stb & ~s_ack_i;
  assign w_tmo   = (TIMEOUT_CYCLES != 0) & w_stall &
                   (r_wdog == WW'(TIMEOUT_CYCLES - 1));

  assign w_pick0 = w_req0 &
                   (~w_req1 | (ROUND_ROBIN == 0) | r_last);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_pick0)     w_next = GRANT0;
        else if (w_req1) w_next = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (w_tmo)       w_next = ABORT;
        else if (!w_cyc) w_next = IDLE;
      end
      ABORT: begin
        if (!w_cyc)      w_next = IDLE;
      end
      default:           w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == GRANT0) r_last <= 1'b0;
      if (r_state == IDLE && w_next == GRANT1) r_last <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wdog <= '0;
    end else if (!w_stall || w_tmo) begin
      r_wdog <= '0;
    end else if (r_wdog != WW'(TIMEOUT_CYCLES)) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = 2'b00;
    if (w_act || r_state == ABORT) begin
      grant_o = {r_last, ~r_last};
    end
    if (w_act && !r_last) begin
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i;
      s_we_o   = m0_we_i;
      s_sel_o  = m0_sel_i;
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      m0_dat_o = s_dat_i;
      m0_ack_o = s_ack_i;
      m0_err_o = w_tmo;
    end
    if (w_act && r_last) begin
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i;
      s_we_o   = m1_we_i;
      s_sel_o  = m1_sel_i;
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      m1_dat_o = s_dat_i;
      m1_ack_o = s_ack_i;
      m1_err_o = w_tmo;
    end
  end

  logic [SW-1:0] w_unused_sw;
  assign w_unused_sw = '0;

endmodule

// File: doc/wb_dual_master_arbiter.md
Name: wb_dual_master_arbiter

Overview:
Arbitrates the Wishbone instruction master (m0) and data master (m1) of a Harvard-style core onto the single core_cyc/core_stb/core_we/core_sel/core_addr/core_data_* bus consumed by the Controller. It sits between the core and the optional PIPELINED_WISHBONE ack/data register stage. It provides round-robin or fixed-priority arbitration, transaction locking, and a watchdog that aborts a transfer when the slave never acks.

Parameters:
ADDR_WIDTH, 32, address width of masters and slave.
DATA_WIDTH, 32, data width; select width is DATA_WIDTH/8.
ROUND_ROBIN, 1, 1 = round-robin on simultaneous requests; 0 = m0 always wins.
TIMEOUT_CYCLES, 1024, number of ack-less strobe cycles before abort; 0 disables the watchdog.

Ports:
clk_i  input  1  core clock
rst_i  input  1  asynchronous active-high reset
mN_cyc_i  input  1  master N bus cycle (N = 0, 1)
mN_stb_i  input  1  master N strobe
mN_we_i  input  1  master N write enable
mN_sel_i  input  DATA_WIDTH/8  master N byte selects
mN_adr_i  input  ADDR_WIDTH  master N address
mN_dat_i  input  DATA_WIDTH  master N write data
mN_dat_o  output  DATA_WIDTH  read data to master N
mN_ack_o  output  1  ack to master N
mN_err_o  output  1  watchdog abort to master N
s_cyc_o, s_stb_o, s_we_o  output  1 each  slave cycle, strobe, write
s_sel_o  output  DATA_WIDTH/8  slave byte selects
s_adr_o  output  ADDR_WIDTH  slave address
s_dat_o  output  DATA_WIDTH  slave write data
s_dat_i  input  DATA_WIDTH  slave read data
s_ack_i  input  1  slave ack
grant_o  output  2  one-hot current owner: bit0 = m0, bit1 = m1

Behaviour:
- Reset is asynchronous on rst_i high.
  - Reset values: state IDLE, last_owner = m1 (so m0 wins the first tie), watchdog = 0.
  - All outputs are 0 during reset.
- States: IDLE, GRANT0, GRANT1, ABORT.
- A request from master N is mN_cyc_i & mN_stb_i.
- IDLE:
  - Slave outputs are all 0 and grant_o = 00.
  - Single request: go to GRANTN next edge.
  - Both requesting: ROUND_ROBIN=1 grants the master that is not last_owner; ROUND_ROBIN=0 grants m0.
  - Arbitration latency is 1 cycle: s_stb_o first rises the cycle after the request.
- GRANTN:
  - s_cyc/stb/we/sel/adr/dat_o mirror master N combinationally.
  - mN_ack_o = s_ack_i.
  - mN_dat_o = s_dat_i; the other master's dat_o is 0 and its ack_o is 0.
  - last_owner is set to N on entry.
  - The grant is held while mN_cyc_i = 1, which locks multi-beat and RMW cycles; the other master waits.
  - When mN_cyc_i = 0: slave cyc drops the same cycle (combinational mirror) and the state returns to IDLE on the next edge. There is no direct GRANT0 to GRANT1 hop; the other master gets its grant on the following edge via IDLE.
- Watchdog:
  - Counts up on each cycle in GRANTN with s_stb_o = 1 and s_ack_i = 0.
  - Clears on s_ack_i, on state exit, and whenever stb is low.
  - When it reaches TIMEOUT_CYCLES:
    - mN_err_o pulses for exactly 1 cycle; the ack is not asserted.
    - Slave cyc/stb are forced to 0 from the next cycle on.
    - State goes to ABORT.
  - The counter saturates; it never wraps.
- ABORT:
  - Slave outputs are 0 and grant_o keeps owner N.
  - A late s_ack_i is ignored and is not forwarded.
  - Exits to IDLE when mN_cyc_i = 0.
- s_ack_i in IDLE or ABORT is dropped silently.
- Simultaneous s_ack_i and timeout-reach in the same cycle: the ack wins, no err is raised, and the watchdog clears.
- Reset asserted mid-transfer: all outputs go to 0 immediately (asynchronous); no ack/err is generated for the lost transfer.

Test Plan:
- Reset, then m0 read at 0x0000_0040 with ack after 2 cycles, s_dat_i = 0xDEADBEEF -> s_stb_o rises 1 cycle after the request; m0_ack_o = 1 with m0_dat_o = 0xDEADBEEF; grant_o = 01; m1_ack_o stays 0.
- m0 and m1 request on the same cycle, ROUND_ROBIN=1, each doing 3 single-beat transfers (cyc dropped between transfers) -> grant order m0, m1, m0, m1, m0, m1.
- Same stimulus with ROUND_ROBIN=0 -> all 3 m0 transfers complete before the first m1 grant.
- m1 write, sel = 4'b0011, adr 0x8000_0010, dat 0x1234_5678, m1 holds cyc across 2 beats while m0 requests -> slave sees both m1 beats with matching we/sel/adr/dat; m0 is granted only after m1_cyc_i falls plus 1 IDLE cycle.
- TIMEOUT_CYCLES=8, slave never acks m0 -> m0_err_o pulses on the 8th stb cycle; s_cyc_o = 0 from the next cycle; an s_ack_i injected in ABORT does not reach m0_ack_o; IDLE after m0 drops cyc.
- Assert rst_i asynchronously mid-m1 transfer -> all outputs 0 before the next clock edge; after release, a tie is granted to m0 first.
